// File: rtl/tl_pkg.sv
// ---------------------------------------------------------------------------
// tl_pkg
// Shared definitions for the traffic-light request scheduler:
//   - tl_state_t         : scheduler FSM state encoding
//   - TL_DEFAULT_MIN_GAP : default settling gap (cycles) after each service
//   - tl_clog2()         : ceiling log2, used to size counters and indices
// ---------------------------------------------------------------------------
package tl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OFFER = 2'd1,
        SERVE = 2'd2,
        GAP   = 2'd3
    } tl_state_t;

    localparam int TL_DEFAULT_MIN_GAP = 8;

    // Smallest width w such that 2**w >= value (0 for value <= 1).
    function automatic int tl_clog2(input int value);
        int width;
        width = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                width = i + 1;
            end
        end
        return width;
    endfunction

endpackage

// File: rtl/tl_sync_edge.sv
// ---------------------------------------------------------------------------
// tl_sync_edge
// Brings one raw asynchronous request line into the clock domain and turns
// each low-to-high transition into a single-cycle pulse.
//   clock     : system clock
//   reset_n   : asynchronous active-low reset
//   async_in  : raw board input, active-high
//   rise      : one-cycle pulse per synchronized rising edge
// ---------------------------------------------------------------------------
module tl_sync_edge #(
    parameter int NSYNC = 2
) (
    input  logic clock,
    input  logic reset_n,
    input  logic async_in,
    output logic rise
);

    logic [NSYNC-1:0] sync_q;
    logic             prev_q;

    // NOTE: the synchronizer and previous-value flops are reset to 0, so a
    // line held high through reset release is seen as exactly one rising edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every stage take its
            // neighbour's pre-edge value, giving a true NSYNC-deep shift.
            sync_q <= {sync_q[NSYNC-2:0], async_in};
            prev_q <= sync_q[NSYNC-1];
        end
    end

    assign rise = sync_q[NSYNC-1] & ~prev_q;

endmodule

// File: rtl/tl_request_scheduler.sv
// ---------------------------------------------------------------------------
// tl_request_scheduler
// Collects pedestrian-button / vehicle-sensor requests, latches them as
// sticky pending bits and hands them one at a time, round-robin, to the
// light sequencer. A fixed settling gap follows each completed service.
//   clock, reset_n : clock and asynchronous active-low reset
//   req_in         : raw asynchronous request lines (N_REQ)
//   grant_valid    : offer of request grant_id to the sequencer
//   grant_id       : index of the offered / in-service request
//   grant_ready    : sequencer accepts the offer
//   serve_done     : one-cycle pulse, phase for grant_id finished
//   pending        : latched, not-yet-accepted requests
//   busy           : scheduler is not IDLE
// ---------------------------------------------------------------------------
module tl_request_scheduler
    import tl_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int NSYNC   = 2,
    parameter int MIN_GAP = TL_DEFAULT_MIN_GAP
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic [N_REQ-1:0]           req_in,
    output logic                       grant_valid,
    output logic [tl_clog2(N_REQ)-1:0] grant_id,
    input  logic                       grant_ready,
    input  logic                       serve_done,
    output logic [N_REQ-1:0]           pending,
    output logic                       busy
);

    localparam int                ID_W     = tl_clog2(N_REQ);
    localparam int                GAP_W    = tl_clog2(MIN_GAP + 1);
    localparam logic [ID_W-1:0]   LAST_ID  = ID_W'(N_REQ - 1);
    localparam logic [GAP_W-1:0]  GAP_LOAD = GAP_W'(MIN_GAP);

    tl_state_t        state_q, state_d;
    logic [ID_W-1:0]  grant_id_q, grant_id_d;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [N_REQ-1:0] pending_q, rise, clear_mask;
    logic [ID_W-1:0]  sel_id, cand_id;
    logic             sel_found;
    int               cand;

    for (genvar i = 0; i < N_REQ; i++) begin : g_sync
        tl_sync_edge #(.NSYNC(NSYNC)) u_sync_edge (
            .clock    (clock),
            .reset_n  (reset_n),
            .async_in (req_in[i]),
            .rise     (rise[i])
        );
    end

    // Round-robin pick: walk offsets from high to low so the lowest offset
    // from rr_ptr (the first set bit searching upward, wrapping) wins.
    always_comb begin
        sel_found = 1'b0;
        sel_id    = '0;
        cand      = 0;
        cand_id   = '0;
        for (int off = N_REQ - 1; off >= 0; off--) begin
            cand = int'(rr_ptr_q) + off;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            cand_id = ID_W'(cand);
            if (pending_q[cand_id]) begin
                sel_found = 1'b1;
                sel_id    = cand_id;
            end
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        grant_id_d = grant_id_q;
        rr_ptr_d   = rr_ptr_q;
        gap_d      = gap_q;
        clear_mask = '0;
        unique case (state_q)
            IDLE: begin
                if (sel_found) begin
                    grant_id_d = sel_id;
                    state_d    = OFFER;
                end
            end
            OFFER: begin
                if (grant_ready) begin
                    clear_mask[grant_id_q] = 1'b1;
                    state_d                = SERVE;
                end
            end
            SERVE: begin
                if (serve_done) begin
                    rr_ptr_d = (grant_id_q == LAST_ID) ? '0 : grant_id_q + ID_W'(1);
                    gap_d    = GAP_LOAD;
                    state_d  = GAP;
                end
            end
            GAP: begin
                gap_d = gap_q - GAP_W'(1);
                if (gap_q == GAP_W'(1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            grant_id_q <= '0;
            rr_ptr_q   <= '0;
            gap_q      <= '0;
            pending_q  <= '0;
        end else begin
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
            rr_ptr_q   <= rr_ptr_d;
            gap_q      <= gap_d;
            // A new edge landing in the accept cycle re-arms the bit.
            pending_q  <= (pending_q & ~clear_mask) | rise;
        end
    end

    assign grant_valid = (state_q == OFFER);
    assign busy        = (state_q != IDLE);
    assign grant_id    = grant_id_q;
    assign pending     = pending_q;

endmodule

// File: tb/tb_tl_request_scheduler.sv
module tb_tl_request_scheduler;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [3:0] req_in;
    logic       grant_valid;
    logic [1:0] grant_id;
    logic       grant_ready;
    logic       serve_done;
    logic [3:0] pending;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int sb_exp;
    logic saw_valid;

    always #5 clock = ~clock;

    tl_request_scheduler #(
        .N_REQ   (4),
        .NSYNC   (2),
        .MIN_GAP (8)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .req_in      (req_in),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .grant_ready (grant_ready),
        .serve_done  (serve_done),
        .pending     (pending),
        .busy        (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Scoreboard: every accepted grant must match the next expected id.
    always @(negedge clock) begin
        if (reset_n === 1'b1 && grant_valid === 1'b1 && grant_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("sb_extra_grant", 32'(grant_id), 32'hff);
            end else begin
                sb_exp = exp_q.pop_front();
                check("sb_grant_id", 32'(grant_id), sb_exp);
            end
        end
    end

    task automatic wait_offer(input int budget);
        int n;
        n = 0;
        while (grant_valid !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check("offer_timeout", 32'(grant_valid), 1);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < budget) begin
            tick();
            n++;
        end
        check("idle_timeout", 32'(busy), 0);
    endtask

    // Wait for an offer, stall it for 'stall' cycles, then accept it.
    task automatic accept_next(input int stall, input int exp_id);
        wait_offer(100);
        check("offer_id", 32'(grant_id), exp_id);
        for (int i = 0; i < stall; i++) begin
            tick();
            check("stall_valid", 32'(grant_valid), 1);
            check("stall_id", 32'(grant_id), exp_id);
        end
        grant_ready = 1'b1;
        tick();
        grant_ready = 1'b0;
        check("serve_valid_low", 32'(grant_valid), 0);
        check("serve_busy", 32'(busy), 1);
    endtask

    task automatic finish_serve(input int delay);
        repeat (delay) tick();
        serve_done = 1'b1;
        tick();
        serve_done = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n     = 1'b0;
        req_in      = 4'b1111;
        grant_ready = 1'b0;
        serve_done  = 1'b0;
        saw_valid   = 1'b0;

        // Reset with all inputs high.
        repeat (3) tick();
        check("rst_valid", 32'(grant_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_pending", 32'(pending), 0);
        check("rst_id", 32'(grant_id), 0);

        reset_n = 1'b1;
        tick();
        tick();
        check("rel_pending_early", 32'(pending), 0);
        tick();
        check("rel_pending", 32'(pending), 4'b1111);
        check("rel_no_offer_yet", 32'(grant_valid), 0);
        req_in = 4'b0000;
        exp_q.push_back(0);
        exp_q.push_back(1);
        exp_q.push_back(2);
        exp_q.push_back(3);
        tick();
        check("rel_offer_valid", 32'(grant_valid), 1);
        check("rel_offer_id", 32'(grant_id), 0);

        // Round robin 0,1,2,3 with a re-request of 0 during service of 1.
        accept_next(0, 0);
        check("rr_pending_a", 32'(pending), 4'b1110);
        finish_serve(5);
        accept_next(0, 1);
        check("rr_pending_b", 32'(pending), 4'b1100);
        req_in[0] = 1'b1;
        exp_q.push_back(0);
        tick();
        req_in[0] = 1'b0;
        finish_serve(4);
        accept_next(0, 2);
        finish_serve(5);
        accept_next(0, 3);
        check("rr_pending_rereq", 32'(pending), 4'b0001);
        finish_serve(5);
        accept_next(0, 0);
        check("rr_pending_empty", 32'(pending), 0);
        finish_serve(5);
        wait_idle(40);

        // Single one-cycle request on input 2, latency and gap length.
        req_in[2] = 1'b1;
        exp_q.push_back(2);
        tick();
        req_in[2] = 1'b0;
        tick();
        check("sr_pending_early", 32'(pending), 0);
        tick();
        check("sr_pending", 32'(pending), 4'b0100);
        check("sr_still_idle", 32'(busy), 0);
        tick();
        check("sr_valid", 32'(grant_valid), 1);
        check("sr_id", 32'(grant_id), 2);
        accept_next(0, 2);
        check("sr_cleared", 32'(pending), 0);
        finish_serve(3);
        repeat (7) tick();
        check("gap_last_cycle_busy", 32'(busy), 1);
        tick();
        check("gap_done_idle", 32'(busy), 0);
        check("gap_done_no_offer", 32'(grant_valid), 0);

        // Strobes outside their states are ignored.
        serve_done  = 1'b1;
        grant_ready = 1'b1;
        tick();
        serve_done  = 1'b0;
        grant_ready = 1'b0;
        tick();
        check("ignored_busy", 32'(busy), 0);
        check("ignored_valid", 32'(grant_valid), 0);

        // Stall for 20 cycles, accept on the 21st.
        req_in[3] = 1'b1;
        exp_q.push_back(3);
        tick();
        req_in[3] = 1'b0;
        accept_next(20, 3);
        finish_serve(2);
        wait_idle(40);

        // Set-wins: a new edge on input 1 lands in its own accept cycle.
        req_in[1] = 1'b1;
        exp_q.push_back(1);
        tick();
        req_in[1] = 1'b0;
        wait_offer(20);
        check("sw_id", 32'(grant_id), 1);
        req_in[1] = 1'b1;
        tick();
        req_in[1] = 1'b0;
        tick();
        grant_ready = 1'b1;
        exp_q.push_back(1);
        tick();
        grant_ready = 1'b0;
        check("sw_pending_kept", 32'(pending), 4'b0010);
        check("sw_in_serve", 32'(busy), 1);
        finish_serve(2);
        accept_next(0, 1);
        check("sw_cleared", 32'(pending), 0);
        finish_serve(2);
        wait_idle(40);

        // Asynchronous reset during SERVE with pending = 1010.
        req_in = 4'b1010;
        exp_q.push_back(3);
        tick();
        req_in = 4'b0000;
        accept_next(0, 3);
        check("rs_pending_a", 32'(pending), 4'b0010);
        req_in[3] = 1'b1;
        tick();
        req_in[3] = 1'b0;
        repeat (3) tick();
        check("rs_pending_b", 32'(pending), 4'b1010);
        check("rs_in_serve", 32'(busy), 1);
        #3;
        reset_n = 1'b0;
        #1;
        check("rs_pending_cleared", 32'(pending), 0);
        check("rs_valid_low", 32'(grant_valid), 0);
        check("rs_busy_low", 32'(busy), 0);
        check("rs_id_zero", 32'(grant_id), 0);
        tick();
        reset_n = 1'b1;
        repeat (30) begin
            tick();
            if (grant_valid === 1'b1) saw_valid = 1'b1;
        end
        check("rs_no_grant", 32'(saw_valid), 0);
        check("rs_pending_after", 32'(pending), 0);

        check("sb_drained", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
